// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- iterative unsigned 16-bit multiply / divide unit
//
// One operation at a time: an accepted request runs 16 iterations (one per
// clock) and then presents a one-cycle register-file write.
//   op 00 : low half of a*b     op 01 : high half of a*b
//   op 10 : a / b (quotient)    op 11 : a % b (remainder)
// Division by zero returns quotient 0xFFFF, remainder a, and raises div_by_zero.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   -> divide/remainder ops are implemented
//   undefined -> divider is absent, requests with op[1]=1 are ignored and
//                div_by_zero is tied low
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        operation request (honoured only while idle)
//   op           operation select
//   src_a        multiplicand / dividend
//   src_b        multiplier / divisor
//   dest_add     destination register address
//   busy         high while an operation is in flight (RUN or DONE)
//   wr_en        one-cycle register-file write strobe
//   wr_reg_add   register-file write address (zero when wr_en is low)
//   wr_data      register-file write data (zero when wr_en is low)
//   div_by_zero  divide-by-zero flag, qualified by wr_en
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic [3:0]        dest_add,
   output logic              busy,
   output logic              wr_en,
   output logic [3:0]        wr_reg_add,
   output logic [DATA_W-1:0] wr_data,
   output logic              div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_ITER = 5'(DATA_W - 1);

   state_t            state;
   logic [4:0]        cnt;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] hi_q;     // product high half / partial remainder
   logic [DATA_W-1:0] lo_q;     // multiplier bits / dividend bits -> quotient
   logic [DATA_W-1:0] hi_nx;
   logic [DATA_W-1:0] lo_nx;
   logic              hi_sel_q; // op[0]: result comes from the high register
   logic [3:0]        dest_q;
   logic              accept;
   logic [DATA_W:0]   mul_sum;
`ifdef MULDIV_DIV_EN
   logic              div_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W-1:0] rem_diff;
`endif

   assign busy = (state != IDLE);

`ifdef MULDIV_DIV_EN
   assign accept = start && (state == IDLE);
`else
   assign accept = start && (state == IDLE) && !op[1];
`endif

   // One iteration of the shared datapath. Multiply: add a if the current
   // multiplier bit is set, then shift {sum, lo} right. Divide: shift the next
   // dividend bit into the remainder and subtract b when it fits.
   always_comb begin
      // NOTE: every signal written here gets a value on every path, so no latch is inferred.
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      hi_nx   = mul_sum[DATA_W:1];
      lo_nx   = {mul_sum[0], lo_q[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
      rem_sh   = {hi_q, lo_q[DATA_W-1]};
      rem_diff = rem_sh[DATA_W-1:0] - b_q;
      if (div_q) begin
         if (rem_sh >= {1'b0, b_q}) begin
            hi_nx = rem_diff;
            lo_nx = {lo_q[DATA_W-2:0], 1'b1};
         end else begin
            hi_nx = rem_sh[DATA_W-1:0];
            lo_nx = {lo_q[DATA_W-2:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state      <= IDLE;
         cnt        <= '0;
         a_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         hi_sel_q   <= 1'b0;
         dest_q     <= '0;
         wr_en      <= 1'b0;
         wr_reg_add <= '0;
         wr_data    <= '0;
`ifdef MULDIV_DIV_EN
         div_q       <= 1'b0;
         b_q         <= '0;
         div_by_zero <= 1'b0;
`endif
      end else begin
         // Write-back outputs are a single-cycle pulse; clear them by default.
         wr_en      <= 1'b0;
         wr_reg_add <= '0;
         wr_data    <= '0;
`ifdef MULDIV_DIV_EN
         div_by_zero <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q      <= src_a;
                  hi_q     <= '0;
                  hi_sel_q <= op[0];
                  dest_q   <= dest_add;
                  cnt      <= '0;
                  state    <= RUN;
`ifdef MULDIV_DIV_EN
                  div_q <= op[1];
                  b_q   <= src_b;
                  lo_q  <= op[1] ? src_a : src_b;
`else
                  lo_q  <= src_b;
`endif
               end
            end
            RUN: begin
               hi_q <= hi_nx;
               lo_q <= lo_nx;
               cnt  <= cnt + 5'd1;
               if (cnt == LAST_ITER) begin
                  state      <= DONE;
                  wr_en      <= 1'b1;
                  wr_reg_add <= dest_q;
                  wr_data    <= hi_sel_q ? hi_nx : lo_nx;
`ifdef MULDIV_DIV_EN
                  div_by_zero <= div_q && (b_q == '0);
`endif
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifndef MULDIV_DIV_EN
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit
//
// Directed vectors for the documented examples, randomized operations checked
// against an arithmetic reference model, back-to-back start pressure and reset
// abort. Expectations adapt to whether MULDIV_DIV_EN is defined.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [15:0] src_a;
   logic [15:0] src_b;
   logic [3:0]  dest_add;
   logic        busy;
   logic        wr_en;
   logic [3:0]  wr_reg_add;
   logic [15:0] wr_data;
   logic        div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   muldiv_unit #(.DATA_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .dest_add    (dest_add),
      .busy        (busy),
      .wr_en       (wr_en),
      .wr_reg_add  (wr_reg_add),
      .wr_data     (wr_data),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: {div_by_zero, result} from plain unsigned arithmetic.
   function automatic logic [16:0] ref_result(input logic [1:0] o, input logic [15:0] a,
                                              input logic [15:0] b);
      logic [31:0] p;
      logic [15:0] r;
      logic        z;
      p = 32'(a) * 32'(b);
      z = 1'b0;
      case (o)
         2'b00: r = p[15:0];
         2'b01: r = p[31:16];
         2'b10: begin z = (b == 0); r = z ? 16'hFFFF : a / b; end
         default: begin z = (b == 0); r = z ? a : a % b; end
      endcase
      return {z, r};
   endfunction

   // Issue one request (caller sits just after a rising edge) and watch 25
   // samples, sample k taken 1 time unit after the k-th edge past the accept.
   task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, output int lat, output int nwr,
                        output logic [15:0] data, output logic [3:0] addr,
                        output logic dbz, output int busy_cyc, output int leak);
      lat = -1; nwr = 0; busy_cyc = 0; leak = 0;
      data = '0; addr = '0; dbz = 1'b0;
      start = 1'b1; op = o; src_a = a; src_b = b; dest_add = d;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); src_a = 16'($urandom); src_b = 16'($urandom);
      dest_add = 4'($urandom);
      for (int k = 0; k <= 24; k++) begin
         if (busy) busy_cyc++;
         if (wr_en) begin
            nwr++;
            if (lat < 0) begin
               lat = k; data = wr_data; addr = wr_reg_add; dbz = div_by_zero;
            end
         end else if (wr_data != 0 || wr_reg_add != 0 || div_by_zero != 0) begin
            leak++;
         end
         if (k < 24) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dest_add = '0;
      #2;
      n_tests++;
      if ({busy, wr_en, wr_reg_add, wr_data, div_by_zero} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b wr_en=%b addr=%h data=%h dbz=%b, expected all 0",
                  busy, wr_en, wr_reg_add, wr_data, div_by_zero);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [1:0]  o;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  d;
      logic [15:0] data;
      logic        dbz;
   } vec_t;

   task automatic test_vectors();
      vec_t v[$];
      int lat, nwr, bc, lk;
      logic [15:0] data;
      logic [3:0] addr;
      logic dbz;
      v.push_back('{2'b00, 16'h1234, 16'h0010, 4'd3,  16'h2340, 1'b0});
      v.push_back('{2'b01, 16'hFFFF, 16'hFFFF, 4'd0,  16'hFFFE, 1'b0});
      v.push_back('{2'b00, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0001, 1'b0});
`ifdef MULDIV_DIV_EN
      v.push_back('{2'b10, 16'd100,  16'd7,    4'd7,  16'h000E, 1'b0});
      v.push_back('{2'b11, 16'd100,  16'd7,    4'd8,  16'h0002, 1'b0});
      v.push_back('{2'b10, 16'h1234, 16'h0000, 4'd1,  16'hFFFF, 1'b1});
      v.push_back('{2'b11, 16'h1234, 16'h0000, 4'd2,  16'h1234, 1'b1});
`endif
      foreach (v[i]) begin
         do_op(v[i].o, v[i].a, v[i].b, v[i].d, lat, nwr, data, addr, dbz, bc, lk);
         n_tests++;
         if (data !== v[i].data || dbz !== v[i].dbz || addr !== v[i].d) begin
            n_fail++;
            $display("FAIL vector%0d_result: got data=%h addr=%h dbz=%b, expected data=%h addr=%h dbz=%b",
                     i, data, addr, dbz, v[i].data, v[i].d, v[i].dbz);
         end
         n_tests++;
         if (lat !== 16 || nwr !== 1 || bc !== 17 || lk !== 0) begin
            n_fail++;
            $display("FAIL vector%0d_timing: got lat=%0d writes=%0d busy=%0d leaks=%0d, expected 16/1/17/0",
                     i, lat, nwr, bc, lk);
         end
      end
`ifndef MULDIV_DIV_EN
      // Divider absent: a divide request must be ignored entirely.
      do_op(2'b10, 16'd100, 16'd7, 4'd4, lat, nwr, data, addr, dbz, bc, lk);
      n_tests++;
      if (nwr !== 0 || bc !== 0) begin
         n_fail++;
         $display("FAIL div_ignored: got writes=%0d busy=%0d, expected 0/0", nwr, bc);
      end
`endif
   endtask

   task automatic test_random(input int n);
      logic [1:0] o;
      logic [15:0] a, b, data;
      logic [3:0] d, addr;
      logic dbz;
      logic [16:0] exp_v;
      int lat, nwr, bc, lk;
      bit acc;
      for (int i = 0; i < n; i++) begin
         o = 2'($urandom);
         a = 16'($urandom);
         case ($urandom_range(0, 4))
            0: b = 16'd0;
            1: b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         d = 4'($urandom);
         exp_v = ref_result(o, a, b);
         acc = DIV_EN || !o[1];
         do_op(o, a, b, d, lat, nwr, data, addr, dbz, bc, lk);
         n_tests++;
         if (acc) begin
            if ({data, addr, dbz} !== {exp_v[15:0], d, exp_v[16]} || lat !== 16 || nwr !== 1
                || bc !== 17 || lk !== 0) begin
               n_fail++;
               $display("FAIL random%0d op=%b a=%h b=%h: got data=%h addr=%h dbz=%b lat=%0d wr=%0d busy=%0d leak=%0d, expected data=%h addr=%h dbz=%b lat=16 wr=1 busy=17 leak=0",
                        i, o, a, b, data, addr, dbz, lat, nwr, bc, lk, exp_v[15:0], d, exp_v[16]);
            end
         end else begin
            if (nwr !== 0 || bc !== 0) begin
               n_fail++;
               $display("FAIL random%0d_ignored op=%b: got writes=%0d busy=%0d, expected 0/0",
                        i, o, nwr, bc);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int wk[$];
      logic [15:0] wd[$];
      logic [3:0] wa[$];
      logic [16:0] e1, e2;
      logic b17, b18;
      b17 = 1'bx; b18 = 1'bx;
      e1 = ref_result(2'b00, 16'h00AB, 16'h0102);
      e2 = ref_result(2'b01, 16'hF00D, 16'h1234);
      start = 1'b1; op = 2'b00; src_a = 16'h00AB; src_b = 16'h0102; dest_add = 4'd5;
      @(posedge clk); #1;
      op = 2'b01; src_a = 16'hF00D; src_b = 16'h1234; dest_add = 4'd9;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (wr_en) begin wk.push_back(k); wd.push_back(wr_data); wa.push_back(wr_reg_add); end
         if (k == 17) b17 = busy;
         if (k == 18) begin b18 = busy; start = 1'b0; end
      end
      n_tests++;
      if (wk.size() !== 2) begin
         n_fail++;
         $display("FAIL b2b_write_count: got %0d, expected 2", wk.size());
      end else begin
         n_tests++;
         if (wk[0] !== 16 || wd[0] !== e1[15:0] || wa[0] !== 4'd5) begin
            n_fail++;
            $display("FAIL b2b_first: got edge=%0d data=%h addr=%h, expected edge=16 data=%h addr=5",
                     wk[0], wd[0], wa[0], e1[15:0]);
         end
         n_tests++;
         if (wk[1] !== 34 || wd[1] !== e2[15:0] || wa[1] !== 4'd9) begin
            n_fail++;
            $display("FAIL b2b_second: got edge=%0d data=%h addr=%h, expected edge=34 data=%h addr=9",
                     wk[1], wd[1], wa[1], e2[15:0]);
         end
      end
      n_tests++;
      if (b17 !== 1'b0 || b18 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_reaccept: got busy@17=%b busy@18=%b, expected 0 and 1", b17, b18);
      end
   endtask

   task automatic test_reset_abort();
      int nwr, nbusy;
      // Abort after 8 RUN edges.
      start = 1'b1; op = 2'b00; src_a = 16'($urandom); src_b = 16'($urandom); dest_add = 4'hA;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_run_immediate: got busy=%b wr_en=%b, expected 0/0", busy, wr_en);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      nwr = 0; nbusy = 0;
      for (int k = 0; k < 30; k++) begin
         if (wr_en) nwr++;
         if (busy) nbusy++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (nwr !== 0 || nbusy !== 0) begin
         n_fail++;
         $display("FAIL abort_run_after: got writes=%0d busy=%0d, expected 0/0", nwr, nbusy);
      end
      // Abort while the write strobe is up.
      start = 1'b1; op = 2'b01; src_a = 16'hBEEF; src_b = 16'h0003; dest_add = 4'h6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (16) begin @(posedge clk); #1; end
      n_tests++;
      if (wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_done_pre: got wr_en=%b, expected 1", wr_en);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || wr_en !== 1'b0 || wr_data !== 16'd0 || wr_reg_add !== 4'd0) begin
         n_fail++;
         $display("FAIL abort_done_immediate: got busy=%b wr_en=%b data=%h addr=%h, expected 0",
                  busy, wr_en, wr_data, wr_reg_add);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      nwr = 0;
      for (int k = 0; k < 30; k++) begin
         if (wr_en) nwr++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (nwr !== 0) begin
         n_fail++;
         $display("FAIL abort_done_after: got writes=%0d, expected 0", nwr);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random(40);
      test_back_to_back();
      test_reset_abort();
      test_random(10);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the operand/result width; 16 is the only supported value.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on rising clk.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULU-lo, 01 MULU-hi, 10 DIVU quotient, 11 REMU remainder.
REQ-006 The block SHALL have port src_a, input, 16 bits: first operand (multiplicand/dividend), from register-file read_data_1.
REQ-007 The block SHALL have port src_b, input, 16 bits: second operand (multiplier/divisor), from register-file read_data_2.
REQ-008 The block SHALL have port dest_add, input, 4 bits: destination register address.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-010 The block SHALL have port wr_en, output, 1 bit: register-file write strobe.
REQ-011 The block SHALL have port wr_reg_add, output, 4 bits: register-file write address.
REQ-012 The block SHALL have port wr_data, output, 16 bits: register-file write data.
REQ-013 The block SHALL have port div_by_zero, output, 1 bit: flag qualified by wr_en.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the rising edge SHALL capture src_a, src_b, op and dest_add, clear the 5-bit iteration counter and move to RUN.
REQ-016 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change until the next accept.
REQ-017 RUN SHALL perform one iteration per edge: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 After exactly 16 RUN edges the FSM SHALL enter DONE, i.e. 16 edges after the accepting edge.
REQ-019 In DONE, for one cycle: wr_en=1, wr_reg_add=captured dest_add, wr_data=result; the next edge SHALL return to IDLE.
REQ-020 wr_en, div_by_zero, wr_reg_add and wr_data SHALL be 0 outside DONE.
REQ-021 The earliest next accept SHALL be the edge after DONE; accept-to-accept minimum is 18 edges.
REQ-022 All arithmetic SHALL be unsigned: MULU-lo = product[15:0], MULU-hi = product[31:16] of the 32-bit product.
REQ-023 DIVU SHALL return floor(a/b) and REMU SHALL return a mod b.
REQ-024 When b=0: DIVU SHALL return 0xFFFF, REMU SHALL return a, div_by_zero=1 in DONE, with the same latency as other operations.
REQ-025 Any destination address 0-15 SHALL be written; no register is special.

Reset
REQ-026 rst low SHALL immediately force IDLE and clear the counter, operands, busy, wr_en, wr_reg_add, wr_data and div_by_zero to 0, regardless of clk.
REQ-027 Reset mid-RUN or in DONE SHALL abort the operation with no write-back, either during or after reset.
REQ-028 The first accept after reset release SHALL occur on the first rising edge with rst high and start=1.

Configuration
REQ-029 With macro MULDIV_DIV_EN defined, ops 10/11 SHALL behave per REQ-023/024.
REQ-030 Without MULDIV_DIV_EN: the divider datapath SHALL be absent; start with op[1]=1 SHALL be ignored (no accept, busy stays 0, no write); div_by_zero SHALL be tied 0; multiply behaviour SHALL be unchanged.

Verification
REQ-031 Bench: MULU-lo 0x1234*0x0010, dest 3 -> busy 1 for 17 cycles; one-cycle wr_en 16 edges after accept; wr_reg_add=3, wr_data=0x2340.
REQ-032 Bench: MULU-hi 0xFFFF*0xFFFF -> wr_data 0xFFFE; same operands with MULU-lo -> 0x0001.
REQ-033 Bench: DIVU 100/7 -> 0x000E; REMU 100/7 -> 0x0002; div_by_zero 0 (macro defined).
REQ-034 Bench: DIVU 0x1234/0 -> 0xFFFF with div_by_zero 1; REMU 0x1234/0 -> 0x1234 with div_by_zero 1.
REQ-035 Bench: start re-asserted every cycle while busy with different op/dest -> exactly one write, using the first captured values; the next accept lands on the edge after DONE.
REQ-036 Bench: rst low after 8 RUN edges -> busy and wr_en 0 immediately; no wr_en pulse after release until a new start.
